// File: rtl/psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// psum_accumulator_if
// Data path between the fusion unit, the partial-sum accumulator and the
// output buffer.
//   psum_valid  : psum_in carries a valid beat this cycle
//   psum_in     : packed partial sums, 4*COL_WIDTH bits
//   acc_out     : per-lane totals, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   out_valid   : acc_out holds a completed job
//   out_ready   : downstream accepts acc_out
// master = producer of psum beats and consumer of results; slave = accumulator.
// -----------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int COL_WIDTH = 13,
  parameter int ACC_WIDTH = 64
);
  logic                     psum_valid;
  logic [4*COL_WIDTH-1:0]   psum_in;
  logic [4*ACC_WIDTH-1:0]   acc_out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output psum_valid, psum_in, out_ready,
    input  acc_out, out_valid
  );

  modport slave (
    input  psum_valid, psum_in, out_ready,
    output acc_out, out_valid
  );
endinterface

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Consumer end of the fusion unit's packed partial-sum output. Each valid
// beat is unpacked into 1, 2 or 4 unsigned lanes (chosen by the weight width
// latched at job start) and added into per-lane accumulators. After acc_len
// valid beats the totals are presented on a valid/ready handshake.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : begin a job (IDLE, or DONE while out_ready is high)
//   acc_len       : valid beats per job, sampled on accepted start
//   weight_width  : lane mode code, sampled on accepted start
//   bus (slave)   : psum_valid/psum_in in, acc_out/out_valid out, out_ready in
//   busy          : high while accumulating
//   overflow      : sticky per job, any lane carried out of ACC_WIDTH
// -----------------------------------------------------------------------------
module psum_accumulator #(
  parameter int COL_WIDTH = 13,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           acc_len,
  input  logic [3:0]           weight_width,
  psum_accumulator_if.slave    bus,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PSUM_W = 4 * COL_WIDTH;
  // One guard bit above the wider of accumulator and lane so the carry-out
  // is visible even in narrow-accumulator builds.
  localparam int SUM_W  = ((ACC_WIDTH > PSUM_W) ? ACC_WIDTH : PSUM_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;
  typedef enum logic [1:0] {MODE_4L, MODE_2L, MODE_1L} mode_e;
  typedef logic [ACC_WIDTH-1:0] acc_t;

  state_e          state_q, state_d;
  mode_e           mode_q,  mode_d;
  logic [7:0]      len_q,   len_d;
  logic [7:0]      cnt_q,   cnt_d;
  acc_t [3:0]      acc_q,   acc_d;
  logic            ovf_q,   ovf_d;

  logic [3:0][PSUM_W-1:0] lane;
  logic [3:0][SUM_W-1:0]  sum;
  logic [3:0]             carry;
  logic                   start_ok;
  logic                   load_job;

  function automatic mode_e decode_mode(input logic [3:0] ww);
    case (ww)
      4'b1000: return MODE_1L;
      4'b0100: return MODE_2L;
      default: return MODE_4L;
    endcase
  endfunction

  // Lane unpack; lanes not used by the current mode stay zero.
  always_comb begin
    lane = '0;
    case (mode_q)
      MODE_1L: lane[0] = bus.psum_in;
      MODE_2L: begin
        lane[0] = PSUM_W'(bus.psum_in[2*COL_WIDTH-1:0]);
        lane[1] = PSUM_W'(bus.psum_in[PSUM_W-1:2*COL_WIDTH]);
      end
      default: begin
        for (int k = 0; k < 4; k++) begin
          lane[k] = PSUM_W'(bus.psum_in[k*COL_WIDTH +: COL_WIDTH]);
        end
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum[k]   = SUM_W'(acc_q[k]) + SUM_W'(lane[k]);
      carry[k] = |sum[k][SUM_W-1:ACC_WIDTH];
    end
  end

  assign start_ok = start && (acc_len != 8'd0);

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this
    // block can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    load_job = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          load_job = 1'b1;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.psum_valid) begin
          for (int k = 0; k < 4; k++) acc_d[k] = sum[k][ACC_WIDTH-1:0];
          ovf_d = ovf_q | (|carry);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Handshake completes on out_ready; a simultaneous start chains
        // straight into the next job without passing through IDLE.
        if (bus.out_ready) begin
          if (start_ok) begin
            load_job = 1'b1;
            state_d  = S_ACCUM;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_job) begin
      acc_d  = '0;
      ovf_d  = 1'b0;
      cnt_d  = 8'd0;
      len_d  = acc_len;
      mode_d = decode_mode(weight_width);
    end
  end

  // NOTE: the accumulator lanes are ordinary flops, not a RAM, so they are
  // reset along with the rest of the state and acc_out reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout sequential logic keep every
      // flop sampling pre-edge values regardless of statement order.
      state_q <= S_IDLE;
      mode_q  <= MODE_4L;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs are decoded straight from registers.
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = (state_q == S_DONE);
  assign busy          = (state_q == S_ACCUM);
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
// Directed and randomised stimulus for psum_accumulator. Inputs change and
// outputs are sampled on the falling clock edge. Expected values come from
// constants or from a reference model that sums lane fields with plain
// integer arithmetic. A second instance with a 16-bit accumulator covers
// the overflow flag.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;
  localparam int C    = 13;
  localparam int AW   = 64;
  localparam int AW16 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start,   start16;
  logic [7:0] acc_len, acc_len16;
  logic [3:0] ww,      ww16;
  logic       busy,    busy16;
  logic       ovf,     ovf16;

  psum_accumulator_if #(.COL_WIDTH(C), .ACC_WIDTH(AW))   bus();
  psum_accumulator_if #(.COL_WIDTH(C), .ACC_WIDTH(AW16)) bus16();

  psum_accumulator #(.COL_WIDTH(C), .ACC_WIDTH(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len),
    .weight_width(ww), .bus(bus), .busy(busy), .overflow(ovf)
  );

  psum_accumulator #(.COL_WIDTH(C), .ACC_WIDTH(AW16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .acc_len(acc_len16),
    .weight_width(ww16), .bus(bus16), .busy(busy16), .overflow(ovf16)
  );

  int tests = 0;
  int fails = 0;
  logic [51:0] beats[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each lane total is the plain integer sum of its field over
  // all absorbed beats; the register shows it modulo 2^aw and overflow is
  // set exactly when that sum reached 2^aw.
  function automatic logic [255:0] model(input logic [3:0] w, input int aw,
                                         input logic [51:0] q[$], output logic o);
    int n, lw;
    logic [127:0] tot, lim, msk;
    logic [255:0] r;
    n   = (w == 4'b1000) ? 1 : (w == 4'b0100) ? 2 : 4;
    lw  = 52 / n;
    lim = 128'd1 << aw;
    msk = (128'd1 << lw) - 128'd1;
    r   = '0;
    o   = 1'b0;
    for (int k = 0; k < n; k++) begin
      tot = '0;
      foreach (q[i]) tot += (128'(q[i]) >> (k * lw)) & msk;
      if (tot >= lim) o = 1'b1;
      r |= 256'(tot % lim) << (k * aw);
    end
    return r;
  endfunction

  task automatic beat(input logic [51:0] d);
    bus.psum_valid = 1'b1;
    bus.psum_in    = d;
    @(negedge clk);
    bus.psum_valid = 1'b0;
  endtask

  task automatic beat16(input logic [51:0] d);
    bus16.psum_valid = 1'b1;
    bus16.psum_in    = d;
    @(negedge clk);
    bus16.psum_valid = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] len, input logic [3:0] w);
    start = 1'b1; acc_len = len; ww = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_acc, held;
    logic         exp_ovf;
    logic [51:0]  d;

    rst = 1'b1;
    start = 1'b0; acc_len = 8'd0; ww = 4'd0;
    start16 = 1'b0; acc_len16 = 8'd0; ww16 = 4'd0;
    bus.psum_valid = 1'b0;   bus.psum_in = '0;   bus.out_ready = 1'b0;
    bus16.psum_valid = 1'b0; bus16.psum_in = '0; bus16.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_acc_out",   bus.acc_out,   '0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      busy,          0);
    check("rst_overflow",  ovf,           0);
    rst = 1'b0;
    @(negedge clk);

    // 4-lane mode, 3 beats, out_valid one cycle after the last beat
    start_job(8'd3, 4'b0010);
    check("t1_busy", busy, 1);
    beat({4{13'd100}});
    beat({4{13'd200}});
    check("t1_not_done_early", bus.out_valid, 0);
    beat({4{13'd8191}});
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_busy_low",  busy, 0);
    check("t1_acc_out",   bus.acc_out, {4{64'd8491}});
    check("t1_overflow",  ovf, 0);
    held = bus.acc_out;
    release_out();
    check("t1_released", bus.out_valid, 0);
    check("t1_acc_kept", bus.acc_out, held);

    // 1-lane mode with bubbles
    start_job(8'd2, 4'b1000);
    beat(52'hF_FFFF_FFFF_FFFF);
    repeat (2) begin
      bus.psum_in = 52'h1234;  // not valid, must be ignored
      @(negedge clk);
      check("t2_bubble_no_done", bus.out_valid, 0);
      check("t2_bubble_busy",    busy, 1);
    end
    beat(52'd1);
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_acc_out",   bus.acc_out, 256'd1 << 52);
    release_out();

    // 2-lane mode with backpressure and dropped beats in DONE
    start_job(8'd1, 4'b0100);
    beat({26'd7, 26'd5});
    repeat (4) begin
      bus.psum_valid = 1'b1;
      bus.psum_in    = 52'({$urandom(), $urandom()});
      @(negedge clk);
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_acc",   bus.acc_out, {64'd0, 64'd0, 64'd7, 64'd5});
    end
    bus.psum_valid = 1'b0;
    release_out();
    check("t3_released", bus.out_valid, 0);
    check("t3_acc_kept", bus.acc_out, {64'd0, 64'd0, 64'd7, 64'd5});

    // Back-to-back jobs: handshake and start in the same cycle
    start_job(8'd1, 4'b0010);
    beat({4{13'd4000}});
    check("t4_first_done", bus.out_valid, 1);
    start = 1'b1; acc_len = 8'd1; ww = 4'b0010; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.out_ready = 1'b0;
    check("t4_chain_busy",  busy, 1);
    check("t4_chain_valid", bus.out_valid, 0);
    check("t4_chain_clear", bus.acc_out, '0);
    beat({13'd1, 13'd2, 13'd3, 13'd4});
    check("t4_second_acc", bus.acc_out, {64'd1, 64'd2, 64'd3, 64'd4});
    release_out();

    // acc_len = 0 start is ignored
    start_job(8'd0, 4'b0010);
    check("t5_len0_busy",  busy, 0);
    check("t5_len0_valid", bus.out_valid, 0);

    // Randomised jobs with mid-job input noise and random backpressure
    for (int j = 0; j < 25; j++) begin
      logic [3:0] wsel;
      int len, sent;
      case ($urandom_range(0, 3))
        0:       wsel = 4'b1000;
        1:       wsel = 4'b0100;
        2:       wsel = 4'b0010;
        default: wsel = 4'($urandom());
      endcase
      len = $urandom_range(1, 8);
      sent = 0;
      beats.delete();
      start_job(8'(len), wsel);
      while (sent < len) begin
        acc_len = 8'($urandom());  // must not affect the running job
        ww      = 4'($urandom());
        d       = 52'({$urandom(), $urandom()});
        if ($urandom_range(0, 3) != 0) begin
          beat(d);
          beats.push_back(d);
          sent++;
        end else begin
          bus.psum_in = d;
          @(negedge clk);
        end
      end
      exp_acc = model(wsel, AW, beats, exp_ovf);
      check($sformatf("rnd%0d_valid", j), bus.out_valid, 1);
      check($sformatf("rnd%0d_acc", j),   bus.acc_out, exp_acc);
      check($sformatf("rnd%0d_ovf", j),   ovf, 256'(exp_ovf));
      repeat ($urandom_range(0, 3)) begin
        bus.psum_valid = 1'b1;
        bus.psum_in    = 52'({$urandom(), $urandom()});
        @(negedge clk);
      end
      bus.psum_valid = 1'b0;
      check($sformatf("rnd%0d_stable", j), bus.acc_out, exp_acc);
      release_out();
      check($sformatf("rnd%0d_idle", j), bus.out_valid, 0);
    end

    // Asynchronous reset mid-ACCUM
    start_job(8'd4, 4'b0010);
    beat({4{13'd55}});
    beat({4{13'd66}});
    #2 rst = 1'b1;
    #1;
    check("t7_rst_acc",   bus.acc_out,   '0);
    check("t7_rst_busy",  busy,          0);
    check("t7_rst_valid", bus.out_valid, 0);
    check("t7_rst_ovf",   ovf,           0);
    @(negedge clk);
    rst = 1'b0;
    beat({4{13'd77}});
    check("t7_after_idle", busy | bus.out_valid, 0);

    // Overflow on the 16-bit accumulator build
    beats.delete();
    start16 = 1'b1; acc_len16 = 8'd8; ww16 = 4'b0010;
    @(negedge clk);
    start16 = 1'b0;
    repeat (8) begin
      beat16({4{13'd8191}});
      beats.push_back({4{13'd8191}});
    end
    exp_acc = model(4'b0010, AW16, beats, exp_ovf);
    check("t8_len8_acc",   bus16.acc_out, {4{16'd65528}});
    check("t8_len8_model", bus16.acc_out, exp_acc);
    check("t8_len8_ovf",   ovf16, 0);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;

    beats.delete();
    start16 = 1'b1; acc_len16 = 8'd9; ww16 = 4'b0010;
    @(negedge clk);
    start16 = 1'b0;
    repeat (9) begin
      beat16({4{13'd8191}});
      beats.push_back({4{13'd8191}});
    end
    exp_acc = model(4'b0010, AW16, beats, exp_ovf);
    check("t8_len9_acc",   bus16.acc_out, {4{16'd8183}});
    check("t8_len9_model", bus16.acc_out, exp_acc);
    check("t8_len9_ovf",   ovf16, 1);
    check("t8_len9_ovf_model", ovf16, 256'(exp_ovf));
    // Overflow stays sticky under backpressure, then clears on a new job
    @(negedge clk);
    check("t8_ovf_sticky", ovf16, 1);
    start16 = 1'b1; acc_len16 = 8'd1; ww16 = 4'b0010; bus16.out_ready = 1'b1;
    @(negedge clk);
    start16 = 1'b0; bus16.out_ready = 1'b0;
    check("t8_ovf_cleared", ovf16, 0);
    check("t8_acc_cleared", bus16.acc_out, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
